// File: rtl/boundary_move_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : boundary_move_ctrl                                              |
// | Brief   : Probes the boundary map ahead of a one-pixel sprite move and    |
// |           commits or blocks it. Define PROBE_FULL_EN to scan the whole    |
// |           candidate footprint instead of only the leading edge.           |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module boundary_move_ctrl #(
  parameter int SPR_W  = 4,
  parameter int SPR_H  = 4,
  parameter int X_INIT = 48,
  parameter int Y_INIT = 30,
  parameter int X_MAX  = 95,
  parameter int Y_MAX  = 63
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       move_req,
  input  logic [1:0] dir,
  output logic [6:0] probe_x,
  output logic [6:0] probe_y,
  input  logic       map_in,
  output logic [6:0] pos_x,
  output logic [6:0] pos_y,
  output logic       busy,
  output logic       done,
  output logic       blocked
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [1:0]        c_DIR_UP    = 2'd0;
  localparam logic [1:0]        c_DIR_DOWN  = 2'd1;
  localparam logic [1:0]        c_DIR_LEFT  = 2'd2;
  localparam logic [1:0]        c_DIR_RIGHT = 2'd3;
  localparam logic signed [7:0] c_NX_MAX    = 8'(X_MAX - SPR_W + 1);
  localparam logic signed [7:0] c_NY_MAX    = 8'(Y_MAX - SPR_H + 1);
  localparam logic [4:0]        c_LAST_COL  = 5'(SPR_W - 1);
  localparam logic [4:0]        c_LAST_ROW  = 5'(SPR_H - 1);
  localparam logic [6:0]        c_X_INIT    = 7'(X_INIT);
  localparam logic [6:0]        c_Y_INIT    = 7'(Y_INIT);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_pos_x, r_pos_y, r_nx, r_ny;
  logic [6:0] w_pos_x_nxt, w_pos_y_nxt, w_nx_nxt, w_ny_nxt;
  logic [1:0] r_dir, w_dir_nxt;
  logic [4:0] r_col, r_row, w_col_nxt, w_row_nxt;
  logic       r_hit, r_first, r_done, r_blocked;
  logic       w_hit_nxt, w_first_nxt, w_done_nxt, w_blocked_nxt;

  logic signed [7:0] w_cx, w_cy;
  logic              w_legal, w_last;
  logic [4:0]        w_col_start, w_row_start;

  // Candidate in 8-bit signed so that stepping off either edge is visible.
  always_comb begin
    w_cx = $signed({1'b0, r_pos_x});
    w_cy = $signed({1'b0, r_pos_y});
    case (dir)
      c_DIR_UP:   w_cy = w_cy - 8'sd1;
      c_DIR_DOWN: w_cy = w_cy + 8'sd1;
      c_DIR_LEFT: w_cx = w_cx - 8'sd1;
      default:    w_cx = w_cx + 8'sd1;
    endcase
    w_legal = (w_cx >= 8'sd0) && (w_cx <= c_NX_MAX) &&
              (w_cy >= 8'sd0) && (w_cy <= c_NY_MAX);
  end

  // Scan origin and end-of-scan detection, expressed as offsets from the candidate.
  always_comb begin
    w_col_start = 5'd0;
    w_row_start = 5'd0;
`ifdef PROBE_FULL_EN
    w_last = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);
`else
    if (dir == c_DIR_DOWN)  w_row_start = c_LAST_ROW;
    if (dir == c_DIR_RIGHT) w_col_start = c_LAST_COL;
    if (r_dir == c_DIR_UP || r_dir == c_DIR_DOWN)
      w_last = (r_col == c_LAST_COL);
    else
      w_last = (r_row == c_LAST_ROW);
`endif
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    w_nx_nxt      = r_nx;
    w_ny_nxt      = r_ny;
    w_dir_nxt     = r_dir;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_hit_nxt     = r_hit;
    w_first_nxt   = r_first;
    w_done_nxt    = 1'b0;
    w_blocked_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (move_req) begin
          w_dir_nxt = dir;
          w_nx_nxt  = w_cx[6:0];
          w_ny_nxt  = w_cy[6:0];
          w_col_nxt = w_col_start;
          w_row_nxt = w_row_start;
          if (!w_legal) begin
            w_hit_nxt     = 1'b1;
            w_state_nxt   = S_COMMIT;
            w_done_nxt    = 1'b1;
            w_blocked_nxt = 1'b1;
          end else begin
            w_hit_nxt   = 1'b0;
            w_first_nxt = 1'b1;
            w_state_nxt = S_PROBE;
          end
        end
      end
      S_PROBE: begin
        // map_in lags the address by one cycle, so the first PROBE cycle carries no result.
        w_first_nxt = 1'b0;
        if (!r_first) w_hit_nxt = r_hit | map_in;
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
`ifdef PROBE_FULL_EN
          if (r_col == c_LAST_COL) begin
            w_col_nxt = 5'd0;
            w_row_nxt = r_row + 5'd1;
          end else begin
            w_col_nxt = r_col + 5'd1;
          end
`else
          if (r_dir == c_DIR_UP || r_dir == c_DIR_DOWN)
            w_col_nxt = r_col + 5'd1;
          else
            w_row_nxt = r_row + 5'd1;
`endif
        end
      end
      S_DRAIN: begin
        w_hit_nxt     = r_hit | map_in;
        w_state_nxt   = S_COMMIT;
        w_done_nxt    = 1'b1;
        w_blocked_nxt = r_hit | map_in;
      end
      default: begin
        w_state_nxt = S_IDLE;
        if (!r_hit) begin
          w_pos_x_nxt = r_nx;
          w_pos_y_nxt = r_ny;
        end
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pos_x   <= c_X_INIT;
      r_pos_y   <= c_Y_INIT;
      r_nx      <= 7'd0;
      r_ny      <= 7'd0;
      r_dir     <= 2'd0;
      r_col     <= 5'd0;
      r_row     <= 5'd0;
      r_hit     <= 1'b0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_nx      <= w_nx_nxt;
      r_ny      <= w_ny_nxt;
      r_dir     <= w_dir_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_hit     <= w_hit_nxt;
      r_first   <= w_first_nxt;
      r_done    <= w_done_nxt;
      r_blocked <= w_blocked_nxt;
    end
  end

  assign probe_x = (r_state == S_IDLE) ? r_pos_x : r_nx + {2'b00, r_col};
  assign probe_y = (r_state == S_IDLE) ? r_pos_y : r_ny + {2'b00, r_row};
  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign blocked = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_boundary_move_ctrl.sv
`timescale 1ns/1ps
// Directed bench for boundary_move_ctrl; a second instance starts on the top row.
module tb_boundary_move_ctrl;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_req = 1'b0, move_req2 = 1'b0;
  logic [1:0] dir = 2'd0, dir2 = 2'd0;
  logic       map_in = 1'b0, map_in2 = 1'b0;
  logic [6:0] probe_x, probe_y, pos_x, pos_y;
  logic [6:0] probe_x2, probe_y2, pos_x2, pos_y2;
  logic       busy, done, blocked, busy2, done2, blocked2;

  int total = 0;
  int bad   = 0;

  logic       solid_on = 1'b0;
  logic [6:0] solid_x = 7'd0, solid_y = 7'd0;
  logic [6:0] px_log [0:63];
  logic [6:0] py_log [0:63];

  boundary_move_ctrl dut (
    .clk50(clk50), .rst_n(rst_n), .move_req(move_req), .dir(dir),
    .probe_x(probe_x), .probe_y(probe_y), .map_in(map_in),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .blocked(blocked)
  );

  boundary_move_ctrl #(.Y_INIT(0)) dut_top (
    .clk50(clk50), .rst_n(rst_n), .move_req(move_req2), .dir(dir2),
    .probe_x(probe_x2), .probe_y(probe_y2), .map_in(map_in2),
    .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .done(done2), .blocked(blocked2)
  );

  always #10 clk50 = ~clk50;

  // Registered boundary map: one solid pixel when enabled.
  always @(posedge clk50) begin
    map_in  <= solid_on && (probe_x == solid_x) && (probe_y == solid_y);
    map_in2 <= 1'b0;
  end

  task automatic apply_reset();
    @(negedge clk50);
    rst_n = 1'b0; move_req = 1'b0; move_req2 = 1'b0;
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
  endtask

  task automatic run_move(input logic [1:0] d, output int dcyc, output logic blk);
    @(negedge clk50);
    dir = d; move_req = 1'b1;
    @(posedge clk50);
    #1 move_req = 1'b0;
    dcyc = -1; blk = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk50);
      if (k < 64) begin px_log[k] = probe_x; py_log[k] = probe_y; end
      if (done) begin dcyc = k; blk = blocked; break; end
    end
    if (dcyc < 0) begin
      total++; bad++;
      $display("FAIL move_timeout: no done within 300 cycles");
    end
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge clk50);
    total++; if (int'(pos_x) !== 48)   begin bad++; $display("FAIL reset_pos_x: got %0d expected 48", pos_x); end
    total++; if (int'(pos_y) !== 30)   begin bad++; $display("FAIL reset_pos_y: got %0d expected 30", pos_y); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (blocked !== 1'b0)     begin bad++; $display("FAIL reset_blocked: got %b expected 0", blocked); end
    total++; if (int'(probe_x) !== 48) begin bad++; $display("FAIL reset_probe_x: got %0d expected 48", probe_x); end
    total++; if (int'(probe_y) !== 30) begin bad++; $display("FAIL reset_probe_y: got %0d expected 30", probe_y); end
    total++; if (int'(pos_y2) !== 0)   begin bad++; $display("FAIL reset_pos_y_top: got %0d expected 0", pos_y2); end
  endtask

  task automatic test_right();
    int dc; logic bk;
    solid_on = 1'b0;
    run_move(2'd3, dc, bk);
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (int'(px_log[i]) !== 52 || int'(py_log[i]) !== 29 + i) begin
        bad++;
        $display("FAIL right_probe[%0d]: got (%0d,%0d) expected (52,%0d)", i, px_log[i], py_log[i], 29 + i);
      end
    end
    total++; if (dc !== 6)    begin bad++; $display("FAIL right_done_cycle: got %0d expected 6", dc); end
    total++; if (bk !== 1'b0) begin bad++; $display("FAIL right_blocked: got %b expected 0", bk); end
    @(negedge clk50);
    total++; if (int'(pos_x) !== 49 || int'(pos_y) !== 30) begin
      bad++; $display("FAIL right_pos: got (%0d,%0d) expected (49,30)", pos_x, pos_y);
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL right_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_illegal_up();
    @(negedge clk50);
    dir2 = 2'd0; move_req2 = 1'b1;
    @(posedge clk50);
    #1 move_req2 = 1'b0;
    @(negedge clk50);
    total++; if (done2 !== 1'b1)    begin bad++; $display("FAIL illegal_done_cycle1: got %b expected 1", done2); end
    total++; if (blocked2 !== 1'b1) begin bad++; $display("FAIL illegal_blocked: got %b expected 1", blocked2); end
    @(negedge clk50);
    total++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL illegal_return_idle: got done=%b busy=%b expected 0 0", done2, busy2);
    end
    total++; if (int'(pos_x2) !== 48 || int'(pos_y2) !== 0) begin
      bad++; $display("FAIL illegal_pos: got (%0d,%0d) expected (48,0)", pos_x2, pos_y2);
    end
  endtask

  task automatic test_blocked_left();
    int dc; logic bk;
    apply_reset();
    solid_on = 1'b1; solid_x = 7'd47; solid_y = 7'd32;
    run_move(2'd2, dc, bk);
    total++; if (int'(px_log[1]) !== 47 || int'(py_log[3]) !== 32) begin
      bad++; $display("FAIL left_probe: got x=%0d y3=%0d expected 47 32", px_log[1], py_log[3]);
    end
    total++; if (dc !== 6)    begin bad++; $display("FAIL left_done_cycle: got %0d expected 6", dc); end
    total++; if (bk !== 1'b1) begin bad++; $display("FAIL left_blocked: got %b expected 1", bk); end
    @(negedge clk50);
    total++; if (int'(pos_x) !== 48 || int'(pos_y) !== 30) begin
      bad++; $display("FAIL left_pos: got (%0d,%0d) expected (48,30)", pos_x, pos_y);
    end
    solid_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cnt; int dcyc [0:7];
    cnt = 0;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk50);
      if (done) begin
        if (cnt < 8) dcyc[cnt] = c;
        cnt++;
      end
      dir = 2'd1;
      move_req = (c < 20);
    end
    move_req = 1'b0;
    total++; if (cnt !== 3) begin bad++; $display("FAIL held_done_count: got %0d expected 3", cnt); end
    if (cnt >= 3) begin
      total++; if (dcyc[0] !== 6) begin bad++; $display("FAIL held_first_done: got %0d expected 6", dcyc[0]); end
      total++; if (dcyc[1] - dcyc[0] !== 7 || dcyc[2] - dcyc[1] !== 7) begin
        bad++; $display("FAIL held_spacing: got %0d,%0d expected 7,7", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
      end
    end
    total++; if (int'(pos_y) !== 33 || int'(pos_x) !== 48) begin
      bad++; $display("FAIL held_pos: got (%0d,%0d) expected (48,33)", pos_x, pos_y);
    end
  endtask

  task automatic test_reset_mid_probe();
    int late_done;
    late_done = 0;
    @(negedge clk50);
    dir = 2'd3; move_req = 1'b1;
    @(posedge clk50);
    #1 move_req = 1'b0;
    @(negedge clk50);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    @(negedge clk50);
    rst_n = 1'b0;
    #1;
    total++; if (int'(pos_x) !== 48 || int'(pos_y) !== 30) begin
      bad++; $display("FAIL midrst_pos: got (%0d,%0d) expected (48,30)", pos_x, pos_y);
    end
    total++; if (busy !== 1'b0 || done !== 1'b0 || blocked !== 1'b0) begin
      bad++; $display("FAIL midrst_flags: got busy=%b done=%b blocked=%b expected 0 0 0", busy, done, blocked);
    end
    total++; if (int'(probe_x) !== 48 || int'(probe_y) !== 30) begin
      bad++; $display("FAIL midrst_probe: got (%0d,%0d) expected (48,30)", probe_x, probe_y);
    end
    @(negedge clk50);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk50);
      if (done) late_done++;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL midrst_abandon: got %0d done pulses expected 0", late_done); end
  endtask

`ifdef PROBE_FULL_EN
  task automatic test_full_footprint();
    int dc; logic bk;
    apply_reset();
    solid_on = 1'b0;
    run_move(2'd1, dc, bk);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (int'(px_log[i + 1]) !== 48 + (i % 4) || int'(py_log[i + 1]) !== 31 + (i / 4)) begin
        bad++;
        $display("FAIL full_probe[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, px_log[i + 1], py_log[i + 1], 48 + (i % 4), 31 + (i / 4));
      end
    end
    total++; if (dc !== 18)   begin bad++; $display("FAIL full_done_cycle: got %0d expected 18", dc); end
    total++; if (bk !== 1'b0) begin bad++; $display("FAIL full_blocked: got %b expected 0", bk); end
    @(negedge clk50);
    total++; if (int'(pos_x) !== 48 || int'(pos_y) !== 31) begin
      bad++; $display("FAIL full_pos: got (%0d,%0d) expected (48,31)", pos_x, pos_y);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_illegal_up();
`ifdef PROBE_FULL_EN
    test_full_footprint();
`else
    test_right();
    test_blocked_left();
    test_back_to_back();
`endif
    test_reset_mid_probe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
